uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 9N1 UART receiver with framing-error detection
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_HZ      = 25000000,
    parameter int BAUD_RATE   = 9600,
    parameter int SAMPLE_RATE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [8:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(SAMPLE_RATE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(SAMPLE_RATE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(SAMPLE_RATE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic [1:0]      warm;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [SW-1:0]   sample_cnt;
    logic [3:0]      bit_cnt;
    logic [8:0]      shift;
    logic            start_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // The synchronizer restarts holding 1s; edges are trusted only once
    // rx_s and rx_prev both carry post-reset line samples.
    always_ff @(posedge clock) begin
        if (reset)
            warm <= 2'd0;
        else if (warm != 2'd3)
            warm <= warm + 1'b1;
    end

    assign start_edge = (state == IDLE) && (warm == 2'd3) && rx_prev && !rx_s;
    assign tick       = (tick_cnt == TICK_LAST);

    always_ff @(posedge clock) begin
        if (reset || start_edge || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= START;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == HALF_LAST) begin
                            sample_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            shift      <= {rx_s, shift[8:1]};
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                data       <= shift;
                                data_valid <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= BREAK;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
